// File: rtl/two_output_stream_demux.sv
`default_nettype none
// ============================================================================
//  Module   : two_output_stream_demux
//  Brief    : Registered 1-to-2 stream demultiplexer. Each input word is
//             steered by in_sel (1 = A, 0 = B) into a one-entry holding
//             register per channel, each with its own valid/ready handshake
//             and wrapping transfer counter.
//  Revision : 1.0 - initial release
// ============================================================================
module two_output_stream_demux #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    input  logic                 clr_count,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    chan_state_e          a_state_q, a_state_d;
    chan_state_e          b_state_q, b_state_d;
    logic [WIDTH-1:0]     a_data_q,  a_data_d;
    logic [WIDTH-1:0]     b_data_q,  b_data_d;
    logic [CNT_WIDTH-1:0] a_count_q, a_count_d;
    logic [CNT_WIDTH-1:0] b_count_q, b_count_d;

    logic w_a_free;
    logic w_b_free;
    logic w_accept;
    logic w_a_load;
    logic w_b_load;
    logic w_a_hs;
    logic w_b_hs;

    // Accept/handshake decode: in_ready looks only at the selected channel,
    // so a stalled channel never holds up words addressed to the other one.
    always_comb begin
        w_a_free = (a_state_q == EMPTY) || a_ready;
        w_b_free = (b_state_q == EMPTY) || b_ready;
        in_ready = in_sel ? w_a_free : w_b_free;
        w_accept = in_valid && in_ready;
        w_a_load = w_accept && in_sel;
        w_b_load = w_accept && !in_sel;
        w_a_hs   = (a_state_q == FULL) && a_ready;
        w_b_hs   = (b_state_q == FULL) && b_ready;
    end

    // Next-state for both channels: a load wins over a drain so a
    // simultaneous handshake + accept reloads the register and stays FULL.
    always_comb begin
        a_state_d = a_state_q;
        b_state_d = b_state_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        a_count_d = a_count_q;
        b_count_d = b_count_q;

        if (w_a_load) begin
            a_state_d = FULL;
            a_data_d  = in_data;
        end else if (w_a_hs) begin
            a_state_d = EMPTY;
        end

        if (w_b_load) begin
            b_state_d = FULL;
            b_data_d  = in_data;
        end else if (w_b_hs) begin
            b_state_d = EMPTY;
        end

        // Clear overrides a same-cycle handshake.
        if (clr_count) begin
            a_count_d = '0;
            b_count_d = '0;
        end else begin
            if (w_a_hs) a_count_d = a_count_q + c_cnt_one;
            if (w_b_hs) b_count_d = b_count_q + c_cnt_one;
        end
    end

    // State registers; reset discards any held words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_q <= EMPTY;
            b_state_q <= EMPTY;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_valid = (a_state_q == FULL);
    assign b_valid = (b_state_q == FULL);
    assign a_data  = a_data_q;
    assign b_data  = b_data_q;
    assign a_count = a_count_q;
    assign b_count = b_count_q;

endmodule
`default_nettype wire

// File: tb/tb_two_output_stream_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_two_output_stream_demux
//  Brief    : Self-checking bench for two_output_stream_demux: per-channel
//             scoreboard queues plus a directed vector table and sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_two_output_stream_demux;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 4;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     in_data;
    logic                 in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_data;
    logic                 a_valid;
    logic                 a_ready;
    logic [WIDTH-1:0]     b_data;
    logic                 b_valid;
    logic                 b_ready;
    logic                 clr_count;
    logic [CNT_WIDTH-1:0] a_count;
    logic [CNT_WIDTH-1:0] b_count;

    two_output_stream_demux #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .clr_count(clr_count),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    logic [WIDTH-1:0]     qa[$];
    logic [WIDTH-1:0]     qb[$];
    logic [CNT_WIDTH-1:0] m_a_cnt = '0;
    logic [CNT_WIDTH-1:0] m_b_cnt = '0;
    logic                 pa_stall = 1'b0;
    logic                 pb_stall = 1'b0;
    logic [WIDTH-1:0]     pa_data  = '0;
    logic [WIDTH-1:0]     pb_data  = '0;
    logic                 mon_en   = 1'b0;

    // Compare the DUT to the model each cycle, then advance the model to
    // what the coming rising edge should produce.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic exp_av, exp_bv, exp_inr;
            exp_av  = (qa.size() != 0);
            exp_bv  = (qb.size() != 0);
            exp_inr = in_sel ? (!exp_av || a_ready) : (!exp_bv || b_ready);
            chk("sb_a_valid", 32'(a_valid), 32'(exp_av));
            chk("sb_b_valid", 32'(b_valid), 32'(exp_bv));
            if (exp_av) chk("sb_a_data", a_data, qa[0]);
            if (exp_bv) chk("sb_b_data", b_data, qb[0]);
            if (pa_stall) chk("sb_a_stable", a_data, pa_data);
            if (pb_stall) chk("sb_b_stable", b_data, pb_data);
            chk("sb_in_ready", 32'(in_ready), 32'(exp_inr));
            chk("sb_a_count", 32'(a_count), 32'(m_a_cnt));
            chk("sb_b_count", 32'(b_count), 32'(m_b_cnt));

            if (exp_av && a_ready) void'(qa.pop_front());
            if (exp_bv && b_ready) void'(qb.pop_front());
            if (in_valid && exp_inr) begin
                if (in_sel) qa.push_back(in_data);
                else        qb.push_back(in_data);
            end
            if (clr_count) begin
                m_a_cnt = '0;
                m_b_cnt = '0;
            end else begin
                if (exp_av && a_ready) m_a_cnt = m_a_cnt + 1'b1;
                if (exp_bv && b_ready) m_b_cnt = m_b_cnt + 1'b1;
            end
            pa_stall = exp_av && !a_ready;
            pb_stall = exp_bv && !b_ready;
            pa_data  = a_data;
            pb_data  = b_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic ar, input logic br, input logic clr);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        a_ready   = ar;
        b_ready   = br;
        clr_count = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        exp_inr;
        logic        exp_av;
        logic        exp_bv;
        logic [31:0] exp_ad;
        logic [31:0] exp_bd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic hold;

        // Stall isolation: A blocked, B flowing. Expected values are the
        // outputs seen during the row's cycle (before its rising edge).
        tbl[0] = '{1'b1, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2};
        tbl[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 32'h3};
        tbl[4] = '{1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_b_valid", 32'(b_valid), 32'h0);
        chk("rst_a_data", a_data, 32'h0);
        chk("rst_b_data", b_data, 32'h0);
        chk("rst_a_count", 32'(a_count), 32'h0);
        chk("rst_b_count", 32'(b_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_sel = 1'b1; #1;
        chk("rst_in_ready_sel1", 32'(in_ready), 32'h1);
        in_sel = 1'b0; #1;
        chk("rst_in_ready_sel0", 32'(in_ready), 32'h1);
        mon_en = 1'b1;
        tick();

        // ---------------- single word to A ----------------
        drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("one_in_ready", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("one_a_valid", 32'(a_valid), 32'h1);
        chk("one_a_data", a_data, 32'hDEADBEEF);
        chk("one_b_valid", 32'(b_valid), 32'h0);
        chk("one_a_count_pre", 32'(a_count), 32'h0);
        tick();
        @(negedge clk);
        chk("one_a_count", 32'(a_count), 32'h1);
        chk("one_a_valid_drain", 32'(a_valid), 32'h0);
        tick();

        // ---------------- stall isolation table ----------------
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_inr));
            chk($sformatf("tbl%0d_a_valid", i), 32'(a_valid), 32'(tbl[i].exp_av));
            chk($sformatf("tbl%0d_b_valid", i), 32'(b_valid), 32'(tbl[i].exp_bv));
            if (tbl[i].exp_av) chk($sformatf("tbl%0d_a_data", i), a_data, tbl[i].exp_ad);
            if (tbl[i].exp_bv) chk($sformatf("tbl%0d_b_data", i), b_data, tbl[i].exp_bd);
            tick();
        end

        // ---------------- full throughput, alternating sel ----------------
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, (i % 2) == 0, 32'(i), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            chk("thru_in_ready", 32'(in_ready), 32'h1);
            if (i > 0) chk("thru_no_bubble", 32'((i % 2) == 1 ? a_valid : b_valid), 32'h1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("thru_a_count", 32'(a_count), 32'(50 % 16));
        chk("thru_b_count", 32'(b_count), 32'(50 % 16));
        tick();

        // ---------------- counter wrap and clear ----------------
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("wrap_a_count", 32'(a_count), 32'h1);
        tick();
        drive(1'b1, 1'b1, 32'h777, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("clr_hs_a_valid", 32'(a_valid), 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("clr_hs_a_count", 32'(a_count), 32'h0);
        tick();

        // ---------------- random backpressure ----------------
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            a_ready   = ($urandom_range(0, 3) != 0);
            b_ready   = ($urandom_range(0, 2) == 0);
            clr_count = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            hold = in_valid && !in_ready;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("rand_drain_a", 32'(qa.size()), 32'h0);
        chk("rand_drain_b", 32'(qb.size()), 32'h0);
        tick();

        // ---------------- mid-stream asynchronous reset ----------------
        drive(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_a_full", 32'(a_valid), 32'h1);
        chk("mid_b_full", 32'(b_valid), 32'h1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(a_valid), 32'h0);
        chk("mid_rst_b_valid", 32'(b_valid), 32'h0);
        chk("mid_rst_a_data", a_data, 32'h0);
        chk("mid_rst_b_data", b_data, 32'h0);
        chk("mid_rst_a_count", 32'(a_count), 32'h0);
        chk("mid_rst_b_count", 32'(b_count), 32'h0);
        qa.delete();
        qb.delete();
        m_a_cnt  = '0;
        m_b_cnt  = '0;
        pa_stall = 1'b0;
        pb_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        in_sel = 1'b1; #1;
        chk("mid_rel_in_ready_a", 32'(in_ready), 32'h1);
        in_sel = 1'b0; #1;
        chk("mid_rel_in_ready_b", 32'(in_ready), 32'h1);
        mon_en = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
